// File: rtl/trap_monitor_pkg.sv
// trap_monitor_pkg: shared types and helpers for the trap monitor.
//   state_e     - monitor FSM states (RUN, DONE, TIMEOUT)
//   chan_w()    - channel-index width for a given channel count, never below 1
//   trap_rec_t  - record layout at the default geometry (W=32, NCH=2, TS_W=24),
//                 handy for decoding records outside the RTL
package trap_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  function automatic int chan_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  localparam int DEF_W    = 32;
  localparam int DEF_NCH  = 2;
  localparam int DEF_TS_W = 24;
  localparam int DEF_CW   = chan_w(DEF_NCH);

  typedef struct packed {
    logic [DEF_W-1:0]    data;
    logic [DEF_CW-1:0]   chan;
    logic [DEF_TS_W-1:0] stamp;
  } trap_rec_t;

endpackage

// File: rtl/trap_monitor_fifo.sv
// trap_fifo: DEPTH x WIDTH record queue with a valid/ready drain side.
//   clk, rst_n      clock, async active-low reset
//   push_i          write push_data_i (ignored when full without a same-cycle pop)
//   push_data_i     record to enqueue
//   full_o          queue full
//   out_valid_o     head record present
//   out_ready_i     consumer takes the head this cycle
//   out_data_o      head record
module trap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit tells full from empty when the addresses match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             pop, wr_en;

  assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign out_valid_o = (wr_ptr_q != rd_ptr_q);
  assign pop         = out_valid_o & out_ready_i;
  // A pop frees the slot the push lands in, so full + pop still accepts.
  assign wr_en       = push_i & (~full_o | pop);
  assign out_data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/trap_monitor.sv
// trap_monitor: captures rising trap edges from NCH cores with their result
// word and a cycle stamp, queues them for a valid/ready drain port, and runs
// a cycle-budget watchdog plus a done flag.
//   clk, rst_n   clock, async active-low reset
//   trap         per-channel trap level
//   data         per-channel result word, channel c = data[c*W +: W]
//   out_valid/out_ready/out_data/out_chan/out_stamp   record drain port
//   overflow     sticky: a record was dropped on a full queue
//   timeout      sticky: watchdog expired before done
//   done         sticky: EXPECT records accepted
module trap_monitor
  import trap_monitor_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int W       = 32,
  parameter int DEPTH   = 8,
  parameter int TS_W    = 24,
  parameter int MAX_CYC = 50000,
  parameter int EXPECT  = 1,
  localparam int CW     = chan_w(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   trap,
  input  logic [NCH*W-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CW-1:0]    out_chan,
  output logic [TS_W-1:0]  out_stamp,
  output logic             overflow,
  output logic             timeout,
  output logic             done
);

  localparam int              ACC_W   = $clog2(EXPECT + 1);
  localparam logic [ACC_W-1:0] ACC_TGT = ACC_W'(EXPECT);
  localparam logic [TS_W-1:0] WD_LAST = TS_W'(MAX_CYC - 1);
  localparam bit              WD_EN   = (MAX_CYC != 0);

  typedef struct packed {
    logic [W-1:0]    data;
    logic [CW-1:0]   chan;
    logic [TS_W-1:0] stamp;
  } rec_t;

  logic [NCH-1:0]   trap_q, pend_q, pend_d, rise, pend_any, cand_oh;
  logic [W-1:0]     hold_q [NCH];
  logic             cand_vld, push, drop, fifo_full, fifo_pop;
  logic [CW-1:0]    cand_idx;
  logic [W-1:0]     cand_data;
  logic             overflow_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [TS_W-1:0]  cnt_q, cnt_d;
  state_e           state_q, state_d;
  rec_t             push_rec, head_rec;

  assign rise = trap & ~trap_q;

  // Arbiter: lowest-index pending channel wins; a same-cycle rise bypasses hold.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    pend_any  = pend_q | rise;
    cand_vld  = 1'b0;
    cand_idx  = '0;
    cand_data = '0;
    cand_oh   = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (pend_any[c]) begin
        cand_vld  = 1'b1;
        cand_idx  = CW'(c);
        cand_data = rise[c] ? data[c*W +: W] : hold_q[c];
        cand_oh   = '0;
        cand_oh[c] = 1'b1;
      end
    end
    // Winner is cleared whether it was pushed or dropped.
    pend_d = pend_any & ~cand_oh;
  end

  assign fifo_pop = out_valid & out_ready;
  assign push     = cand_vld & (~fifo_full | fifo_pop);
  assign drop     = cand_vld & fifo_full & ~fifo_pop;
  assign acc_d    = (push && acc_q != ACC_TGT) ? acc_q + ACC_W'(1) : acc_q;

  // FSM next state and cycle counter; the counter only advances while staying in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (acc_d == ACC_TGT) begin
          state_d = ST_DONE;
        end else if (WD_EN && cnt_q == WD_LAST) begin
          state_d = ST_TIMEOUT;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TS_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q     <= '0;
      pend_q     <= '0;
      overflow_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      state_q    <= ST_RUN;
      for (int c = 0; c < NCH; c++) hold_q[c] <= '0;
    end else begin
      trap_q     <= trap;
      pend_q     <= pend_d;
      overflow_q <= overflow_q | drop;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      for (int c = 0; c < NCH; c++) begin
        if (rise[c]) hold_q[c] <= data[c*W +: W];
      end
    end
  end

  assign push_rec = '{data: cand_data, chan: cand_idx, stamp: cnt_q};

  trap_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_rec),
    .full_o      (fifo_full),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (head_rec)
  );

  assign out_data  = head_rec.data;
  assign out_chan  = head_rec.chan;
  assign out_stamp = head_rec.stamp;
  assign overflow  = overflow_q;
  assign done      = (state_q == ST_DONE);
  assign timeout   = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_trap_monitor.sv
// Bench for trap_monitor: u_a (NCH=1, EXPECT=1) for the single-trap/done case,
// u_b (NCH=2, MAX_CYC=50) for ordering, overflow, watchdog, backpressure and reset.
// u_b records are checked through a scoreboard queue filled when traps are driven.
module tb_trap_monitor;
  import trap_monitor_pkg::*;

  localparam int MAXB = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u_a
  logic        rst_a, trap_a, ready_a;
  logic [31:0] data_a, odata_a;
  logic [0:0]  ochan_a;
  logic [23:0] ostamp_a;
  logic        valid_a, ovf_a, to_a, done_a;

  // u_b
  logic        rst_b, ready_b;
  logic [1:0]  trap_b;
  logic [63:0] data_b;
  logic [31:0] odata_b;
  logic [0:0]  ochan_b;
  logic [23:0] ostamp_b;
  logic        valid_b, ovf_b, to_b, done_b;

  trap_monitor #(.NCH(1), .EXPECT(1)) u_a (
    .clk(clk), .rst_n(rst_a), .trap(trap_a), .data(data_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_data(odata_a),
    .out_chan(ochan_a), .out_stamp(ostamp_a),
    .overflow(ovf_a), .timeout(to_a), .done(done_a)
  );

  trap_monitor #(.NCH(2), .MAX_CYC(MAXB), .EXPECT(16)) u_b (
    .clk(clk), .rst_n(rst_b), .trap(trap_b), .data(data_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_data(odata_b),
    .out_chan(ochan_b), .out_stamp(ostamp_b),
    .overflow(ovf_b), .timeout(to_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  bit frz_b = 1'b0;
  int pops_b = 0;
  trap_rec_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven 1 time unit after the edge.
  // The counter models track the value each DUT holds during the new cycle.
  task automatic tick();
    @(posedge clk);
    if (rst_a) cnt_a++;
    if (rst_b && !frz_b) begin
      if (cnt_b == MAXB - 1) frz_b = 1'b1;
      else cnt_b++;
    end
    #1;
  endtask

  task automatic expect_b(input logic [31:0] d, input logic c, input int s);
    trap_rec_t r;
    r.data  = d;
    r.chan  = c;
    r.stamp = 24'(s);
    sb.push_back(r);
  endtask

  task automatic reset_b();
    rst_b  = 1'b0;
    trap_b = '0;
    data_b = '0;
    ready_b = 1'b0;
    tick();
    tick();
    sb.delete();
    pops_b = 0;
    cnt_b  = 0;
    frz_b  = 1'b0;
    rst_b  = 1'b1;
  endtask

  // Scoreboard drain and stall-stability monitor, sampled mid-cycle.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic [0:0]  prev_c;
  logic [23:0] prev_s;
  always @(negedge clk) begin
    if (!rst_b) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", valid_b, 1'b1);
        check("stall_data", odata_b, prev_d);
        check("stall_chan", ochan_b, prev_c);
        check("stall_stamp", ostamp_b, prev_s);
      end
      if (valid_b && ready_b) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_unexpected observed data %0d chan %0d stamp %0d expected no record",
                 odata_b, ochan_b, ostamp_b);
        end else begin
          trap_rec_t e;
          e = sb.pop_front();
          check("sb_data", odata_b, e.data);
          check("sb_chan", ochan_b, e.chan);
          check("sb_stamp", ostamp_b, e.stamp);
        end
        pops_b++;
      end
      prev_stall = valid_b & ~ready_b;
      prev_d = odata_b;
      prev_c = ochan_b;
      prev_s = ostamp_b;
    end
  end

  initial begin
    rst_a = 1'b0; trap_a = 1'b0; data_a = '0; ready_a = 1'b0;
    rst_b = 1'b0; trap_b = '0;   data_b = '0; ready_b = 1'b0;
    #1;
    check("rst_a_valid", valid_a, 1'b0);
    check("rst_a_flags", {ovf_a, to_a, done_a}, 3'b000);
    check("rst_b_valid", valid_b, 1'b0);
    check("rst_b_flags", {ovf_b, to_b, done_b}, 3'b000);
    tick();
    tick();
    cnt_a = 0;
    rst_a = 1'b1;

    // 1 single trap on u_a at cycle 100
    while (cnt_a < 100) tick();
    check("t1_pre_valid", valid_a, 1'b0);
    check("t1_pre_done", done_a, 1'b0);
    trap_a = 1'b1;
    data_a = 32'd25;
    tick();
    check("t1_valid", valid_a, 1'b1);
    check("t1_data", odata_a, 32'd25);
    check("t1_chan", ochan_a, 1'b0);
    check("t1_stamp", ostamp_a, 24'd100);
    check("t1_done", done_a, 1'b1);
    check("t1_timeout", to_a, 1'b0);

    // 2 simultaneous rises on u_b
    reset_b();
    ready_b = 1'b1;
    tick(); tick(); tick();
    trap_b = 2'b11;
    data_b = {32'd9, 32'd7};
    expect_b(32'd7, 1'b0, cnt_b);
    expect_b(32'd9, 1'b1, cnt_b + 1);
    tick();
    check("t2_lat_valid", valid_b, 1'b1);
    check("t2_lat_data", odata_b, 32'd7);
    tick(); tick(); tick();
    trap_b = 2'b00;
    tick();
    check("t2_drained", sb.size(), 0);
    check("t2_pops", pops_b, 2);

    // 3 overflow: 9 traps into an 8-deep queue with no drain
    reset_b();
    for (int k = 0; k < 9; k++) begin
      if (k == 8) check("t3_no_ovf_yet", ovf_b, 1'b0);
      trap_b = 2'b01;
      data_b = {32'd0, 32'(100 + k)};
      if (k < 8) expect_b(32'(100 + k), 1'b0, cnt_b);
      tick();
      trap_b = 2'b00;
      tick();
    end
    check("t3_ovf", ovf_b, 1'b1);
    check("t3_head", odata_b, 32'd100);
    ready_b = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    ready_b = 1'b0;
    check("t3_pops", pops_b, 8);
    check("t3_drained", sb.size(), 0);
    check("t3_empty", valid_b, 1'b0);
    check("t3_ovf_sticky", ovf_b, 1'b1);

    // 5 backpressure: ready toggles every cycle while 4 traps arrive
    reset_b();
    for (int k = 0; k < 4; k++) begin
      trap_b = (k % 2 == 0) ? 2'b01 : 2'b10;
      data_b = (k % 2 == 0) ? {32'd0, 32'(200 + k)} : {32'(200 + k), 32'd0};
      expect_b(32'(200 + k), 1'(k % 2), cnt_b);
      tick();
      ready_b = ~ready_b;
      trap_b = 2'b00;
      tick();
      ready_b = ~ready_b;
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      ready_b = ~ready_b;
    end
    ready_b = 1'b1;
    tick(); tick(); tick();
    ready_b = 1'b0;
    check("t5_pops", pops_b, 4);
    check("t5_drained", sb.size(), 0);
    check("t5_ovf", ovf_b, 1'b0);

    // 4 watchdog: no traps for the whole budget, then traps after timeout
    reset_b();
    for (int k = 0; k < MAXB - 1; k++) tick();
    check("t4_pre_timeout", to_b, 1'b0);
    tick();
    check("t4_timeout", to_b, 1'b1);
    tick(); tick(); tick();
    for (int k = 0; k < 4; k++) begin
      trap_b = 2'b01;
      data_b = {32'd0, 32'(300 + k)};
      expect_b(32'(300 + k), 1'b0, cnt_b);
      tick();
      trap_b = 2'b00;
      tick();
    end
    check("t4_valid", valid_b, 1'b1);
    check("t4_done", done_b, 1'b0);
    check("t4_timeout_hold", to_b, 1'b1);
    ready_b = 1'b1;
    tick();
    ready_b = 1'b0;
    check("t4_pops", pops_b, 1);

    // 6 asynchronous reset with 3 records still queued
    tick();
    check("t6_pre_valid", valid_b, 1'b1);
    rst_b = 1'b0;
    #1;
    check("t6_valid", valid_b, 1'b0);
    check("t6_flags", {ovf_b, to_b, done_b}, 3'b000);
    sb.delete();
    tick();
    rst_b = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
